// File: rtl/jtag_pkg.sv
// ============================================================================
// Package : jtag_pkg
// Brief   : TAP state encodings, default opcodes, IDCODE word, IR capture
//           pattern and the 1149.1 next-state function.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package jtag_pkg;

   typedef enum logic [3:0] {
      TLR     = 4'hF,
      RTI     = 4'hC,
      SELDR   = 4'h7,
      CAPDR   = 4'h6,
      SHDR    = 4'h2,
      EX1DR   = 4'h1,
      PAUSEDR = 4'h3,
      EX2DR   = 4'h0,
      UPDDR   = 4'h5,
      SELIR   = 4'h4,
      CAPIR   = 4'hE,
      SHIR    = 4'hA,
      EX1IR   = 4'h9,
      PAUSEIR = 4'hB,
      EX2IR   = 4'h8,
      UPDIR   = 4'hD
   } tap_state_t;

   localparam logic [7:0]  DEF_ER1_OPCODE    = 8'h32;
   localparam logic [7:0]  DEF_ER2_OPCODE    = 8'h38;
   localparam logic [7:0]  DEF_BYPASS_OPCODE = 8'hFF;
   localparam logic [7:0]  DEF_IDCODE_OPCODE = 8'h01;
   localparam logic [31:0] DEF_IDCODE_VALUE  = 32'h0000_0001;
   localparam logic [1:0]  IR_CAPTURE        = 2'b01;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      tap_state_t n;
      n = TLR;
      case (s)
         TLR:     n = tms ? TLR   : RTI;
         RTI:     n = tms ? SELDR : RTI;
         SELDR:   n = tms ? SELIR : CAPDR;
         CAPDR:   n = tms ? EX1DR : SHDR;
         SHDR:    n = tms ? EX1DR : SHDR;
         EX1DR:   n = tms ? UPDDR : PAUSEDR;
         PAUSEDR: n = tms ? EX2DR : PAUSEDR;
         EX2DR:   n = tms ? UPDDR : SHDR;
         UPDDR:   n = tms ? SELDR : RTI;
         SELIR:   n = tms ? TLR   : CAPIR;
         CAPIR:   n = tms ? EX1IR : SHIR;
         SHIR:    n = tms ? EX1IR : SHIR;
         EX1IR:   n = tms ? UPDIR : PAUSEIR;
         PAUSEIR: n = tms ? EX2IR : PAUSEIR;
         EX2IR:   n = tms ? UPDIR : SHIR;
         UPDIR:   n = tms ? SELDR : RTI;
         default: n = TLR;
      endcase
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
// ============================================================================
// Module  : jtag_tap_fsm
// Brief   : 16-state TAP state register with registered one-hot decodes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tms,
   output tap_state_t state,
   output logic       enter_tlr,
   output logic       tlr,
   output logic       capdr,
   output logic       shdr,
   output logic       upddr,
   output logic       capir,
   output logic       shir,
   output logic       updir
);

   tap_state_t nxt;

   assign nxt       = tap_next(state, tms);
   assign enter_tlr = (nxt == TLR);

   // Decodes are registered from the next state so they always mirror state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= TLR;
         tlr   <= 1'b1;
         capdr <= 1'b0;
         shdr  <= 1'b0;
         upddr <= 1'b0;
         capir <= 1'b0;
         shir  <= 1'b0;
         updir <= 1'b0;
      end else begin
         state <= nxt;
         tlr   <= (nxt == TLR);
         capdr <= (nxt == CAPDR);
         shdr  <= (nxt == SHDR);
         upddr <= (nxt == UPDDR);
         capir <= (nxt == CAPIR);
         shir  <= (nxt == SHIR);
         updir <= (nxt == UPDIR);
      end
   end

endmodule

`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
// ============================================================================
// Module  : jtag_tap_ctrl
// Brief   : JTAG TAP controller, IR, BYPASS and ER1/ER2 chain strobes/TDO mux.
// Options : JTAG_IDCODE_EN adds the 32-bit IDCODE data register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int                  IR_WIDTH      = 8,
   parameter logic [IR_WIDTH-1:0] ER1_OPCODE    = IR_WIDTH'(DEF_ER1_OPCODE),
   parameter logic [IR_WIDTH-1:0] ER2_OPCODE    = IR_WIDTH'(DEF_ER2_OPCODE),
   parameter logic [IR_WIDTH-1:0] BYPASS_OPCODE = IR_WIDTH'(DEF_BYPASS_OPCODE),
   parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = IR_WIDTH'(DEF_IDCODE_OPCODE),
   parameter logic [31:0]         IDCODE_VALUE  = DEF_IDCODE_VALUE
)(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                TMS,
   input  logic                TDI,
   output logic                TDO,
   output logic                TDO_EN,
   input  logic                ER1_TDO,
   input  logic                ER2_TDO,
   output logic                ER1_CLKEN,
   output logic                ER2_CLKEN,
   output logic                CAPTURE_DR,
   output logic                ER1_UPDATE,
   output logic                ER2_UPDATE,
   output logic [IR_WIDTH-1:0] IR_OUT,
   output logic [3:0]          TAP_STATE
);

   tap_state_t          state;
   logic                enter_tlr;
   logic                st_tlr, st_capdr, st_shdr, st_upddr, st_capir, st_shir, st_updir;
   logic [IR_WIDTH-1:0] ir;
   logic [IR_WIDTH-1:0] ir_sr;
   logic                bypass;
   logic                tdo_r;
   logic                sel_er1, sel_er2, sel_idcode;
   logic                idcode_lsb;
   logic                dr_out;
   logic                unused_cfg;

   jtag_tap_fsm u_fsm (
      .clk       (CLK),
      .rst       (RESET),
      .tms       (TMS),
      .state     (state),
      .enter_tlr (enter_tlr),
      .tlr       (st_tlr),
      .capdr     (st_capdr),
      .shdr      (st_shdr),
      .upddr     (st_upddr),
      .capir     (st_capir),
      .shir      (st_shir),
      .updir     (st_updir)
   );

   assign unused_cfg = ^{BYPASS_OPCODE, IDCODE_OPCODE, IDCODE_VALUE};

   assign sel_er1 = (ir == ER1_OPCODE);
   assign sel_er2 = (ir == ER2_OPCODE);

`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OPCODE;

   logic [31:0] idcode_sr;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idcode_sr <= IDCODE_VALUE;
      end else if (st_capdr) begin
         idcode_sr <= IDCODE_VALUE;
      end else if (st_shdr) begin
         idcode_sr <= {TDI, idcode_sr[31:1]};
      end
   end

   assign sel_idcode = (ir == IDCODE_OPCODE) && !sel_er1 && !sel_er2;
   assign idcode_lsb = idcode_sr[0];
`else
   localparam logic [IR_WIDTH-1:0] IR_RESET = BYPASS_OPCODE;

   assign sel_idcode = 1'b0;
   assign idcode_lsb = 1'b0;
`endif

   // Entering TLR clears the IR path on the same edge, so TLR always shows reset values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ir     <= IR_RESET;
         ir_sr  <= '0;
         bypass <= 1'b0;
      end else if (enter_tlr) begin
         ir     <= IR_RESET;
         ir_sr  <= '0;
         bypass <= 1'b0;
      end else begin
         if (st_capir) begin
            ir_sr <= IR_WIDTH'(IR_CAPTURE);
         end else if (st_shir) begin
            ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
         end
         if (st_updir) begin
            ir <= ir_sr;
         end
         if (st_capdr) begin
            bypass <= 1'b0;
         end else if (st_shdr) begin
            bypass <= TDI;
         end
      end
   end

   assign dr_out = sel_er1    ? ER1_TDO    :
                   sel_er2    ? ER2_TDO    :
                   sel_idcode ? idcode_lsb : bypass;

   // ER chain outputs are also latched here so TDO holds after the shift ends.
   always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) begin
         tdo_r <= 1'b0;
      end else if (st_tlr) begin
         tdo_r <= 1'b0;
      end else if (st_shir) begin
         tdo_r <= ir_sr[0];
      end else if (st_shdr) begin
         tdo_r <= dr_out;
      end
   end

   assign TDO        = (st_shdr && (sel_er1 || sel_er2)) ? dr_out : tdo_r;
   assign TDO_EN     = st_shir | st_shdr;
   assign ER1_CLKEN  = (st_capdr | st_shdr) & sel_er1;
   assign ER2_CLKEN  = (st_capdr | st_shdr) & sel_er2;
   assign CAPTURE_DR = st_capdr;
   assign ER1_UPDATE = st_upddr & sel_er1;
   assign ER2_UPDATE = st_upddr & sel_er2;
   assign IR_OUT     = ir;
   assign TAP_STATE  = state;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
// ============================================================================
// Module  : tb_jtag_tap_ctrl
// Brief   : Self-checking bench for jtag_tap_ctrl against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jtag_tap_ctrl;

   localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                          S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0,
                          S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                          S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;
`ifdef JTAG_IDCODE_EN
   localparam bit         IDC    = 1'b1;
   localparam logic [7:0] IR_DEF = 8'h01;
`else
   localparam bit         IDC    = 1'b0;
   localparam logic [7:0] IR_DEF = 8'hFF;
`endif
   localparam logic [31:0] IDV = 32'h0000_0001;

   logic       clk = 1'b0, rst = 1'b1, tms = 1'b1, tdi = 1'b0, er1_tdo = 1'b0, er2_tdo = 1'b0;
   logic       tdo, tdo_en, er1_clken, er2_clken, capture_dr, er1_update, er2_update;
   logic [7:0] ir_out;
   logic [3:0] tap_state;

   int n_checks = 0;
   int n_errors = 0;

   jtag_tap_ctrl dut (
      .CLK(clk), .RESET(rst), .TMS(tms), .TDI(tdi), .TDO(tdo), .TDO_EN(tdo_en),
      .ER1_TDO(er1_tdo), .ER2_TDO(er2_tdo), .ER1_CLKEN(er1_clken), .ER2_CLKEN(er2_clken),
      .CAPTURE_DR(capture_dr), .ER1_UPDATE(er1_update), .ER2_UPDATE(er2_update),
      .IR_OUT(ir_out), .TAP_STATE(tap_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [3:0] nx0 [16];
   logic [3:0] nx1 [16];
   logic [3:0] m_st;
   logic [7:0] m_ir;
   bit         irq [$];
   bit         bpq [$];
   bit         idq [$];
   logic       m_tdo;

   task automatic tr(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
      nx0[s] = a; nx1[s] = b;
   endtask

   task automatic init_table();
      tr(S_TLR, S_RTI, S_TLR);       tr(S_RTI, S_RTI, S_SELDR);
      tr(S_SELDR, S_CAPDR, S_SELIR); tr(S_CAPDR, S_SHDR, S_EX1DR);
      tr(S_SHDR, S_SHDR, S_EX1DR);   tr(S_EX1DR, S_PAUSEDR, S_UPDDR);
      tr(S_PAUSEDR, S_PAUSEDR, S_EX2DR); tr(S_EX2DR, S_SHDR, S_UPDDR);
      tr(S_UPDDR, S_RTI, S_SELDR);   tr(S_SELIR, S_CAPIR, S_TLR);
      tr(S_CAPIR, S_SHIR, S_EX1IR);  tr(S_SHIR, S_SHIR, S_EX1IR);
      tr(S_EX1IR, S_PAUSEIR, S_UPDIR); tr(S_PAUSEIR, S_PAUSEIR, S_EX2IR);
      tr(S_EX2IR, S_SHIR, S_UPDIR);  tr(S_UPDIR, S_RTI, S_SELDR);
   endtask

   task automatic model_clear_ir();
      m_ir = IR_DEF;
      irq.delete(); repeat (8) irq.push_back(1'b0);
      bpq.delete(); bpq.push_back(1'b0);
   endtask

   task automatic model_reset();
      m_st = S_TLR;
      model_clear_ir();
      idq.delete(); repeat (32) idq.push_back(1'b0);
      m_tdo = 1'b0;
   endtask

   function automatic int m_sel();
      if (m_ir == 8'h32) return 1;
      if (m_ir == 8'h38) return 2;
      if (IDC && m_ir == 8'h01) return 3;
      return 0;
   endfunction

   task automatic model_pos(input logic t, input logic d);
      case (m_st)
         S_CAPIR: begin irq.delete(); for (int i = 0; i < 8; i++) irq.push_back(i == 0); end
         S_SHIR:  begin void'(irq.pop_front()); irq.push_back(d); end
         S_UPDIR: for (int i = 0; i < 8; i++) m_ir[i] = irq[i];
         S_CAPDR: begin
            bpq.delete(); bpq.push_back(1'b0);
            idq.delete(); for (int i = 0; i < 32; i++) idq.push_back(IDV[i]);
         end
         S_SHDR: begin
            void'(bpq.pop_front()); bpq.push_back(d);
            void'(idq.pop_front()); idq.push_back(d);
         end
         default: ;
      endcase
      m_st = t ? nx1[m_st] : nx0[m_st];
      if (m_st == S_TLR) model_clear_ir();
   endtask

   task automatic model_neg();
      case (m_st)
         S_TLR:  m_tdo = 1'b0;
         S_SHIR: m_tdo = irq[0];
         S_SHDR: case (m_sel())
                    1: m_tdo = er1_tdo;
                    2: m_tdo = er2_tdo;
                    3: m_tdo = idq[0];
                    default: m_tdo = bpq[0];
                 endcase
         default: ;
      endcase
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic t, input logic d);
      tms = t; tdi = d;
      @(posedge clk); model_pos(t, d);
      @(negedge clk); #1; model_neg();
   endtask

   task automatic goto_rti();
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic scan_ir(input logic [7:0] v);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 8; i++) step(i == 7, v[i]);
      step(1, 0); step(0, 0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int sc = 0; sc < 2; sc++) begin
         goto_rti(); scan_ir(8'h32);
         if (sc == 0) begin step(1, 0); step(0, 0); step(0, 0); step(0, 1); end
         else begin step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 0); step(0, 0); step(0, 1); end
         rst = 1'b1; model_reset(); #1;
         n_checks++;
         if ({tap_state, ir_out, tdo_en, capture_dr, er1_clken, er2_clken, er1_update, er2_update, tdo}
             !== {S_TLR, IR_DEF, 7'b0}) begin
            n_errors++;
            $display("FAIL reset_async: got st=%h ir=%h en=%b cap=%b ck=%b%b up=%b%b tdo=%b want st=F ir=%h rest 0",
                     tap_state, ir_out, tdo_en, capture_dr, er1_clken, er2_clken, er1_update, er2_update, tdo, IR_DEF);
         end
         repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if ({er1_update, er2_update, tap_state, ir_out} !== {2'b00, S_TLR, IR_DEF}) begin
               n_errors++;
               $display("FAIL reset_hold: got up=%b%b st=%h ir=%h want up=00 st=F ir=%h",
                        er1_update, er2_update, tap_state, ir_out, IR_DEF);
            end
         end
         @(negedge clk); #1; rst = 1'b0;
         step(1, 0);
         n_checks++;
         if ({tap_state, ir_out} !== {S_TLR, IR_DEF}) begin
            n_errors++;
            $display("FAIL reset_release: got st=%h ir=%h want st=F ir=%h", tap_state, ir_out, IR_DEF);
         end
      end
   endtask

   task automatic test_tlr();
      for (int n = 0; n < 6; n++) begin
         goto_rti();
         step(1, 0); step(1, 0); step(0, 0); step(0, 0);
         repeat ($urandom_range(0, 5)) step(0, 1'($urandom));
         repeat (4) step(1, 0);
         n_checks++;
         if (tap_state !== S_SELIR) begin
            n_errors++;
            $display("FAIL tlr_4ones: got st=%h want st=%h", tap_state, S_SELIR);
         end
         step(1, 0);
         n_checks++;
         if ({tap_state, ir_out} !== {S_TLR, IR_DEF}) begin
            n_errors++;
            $display("FAIL tlr_5ones: got st=%h ir=%h want st=F ir=%h", tap_state, ir_out, IR_DEF);
         end
      end
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 12)) step(1'($urandom), 1'($urandom));
         repeat (5) step(1, 0);
         n_checks++;
         if (tap_state !== S_TLR) begin
            n_errors++;
            $display("FAIL tlr_walk: got st=%h want st=F", tap_state);
         end
      end
   endtask

   task automatic test_ir_load();
      logic [7:0] v, old;
      for (int n = 0; n < 3; n++) begin
         v = (n == 0) ? 8'h32 : 8'($urandom);
         goto_rti(); old = m_ir;
         step(1, 0); step(1, 0); step(0, 0); step(0, 0);
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tdo !== (i == 0)) begin
               n_errors++;
               $display("FAIL ir_capture_bit%0d: got tdo=%b want %b", i, tdo, (i == 0));
            end
            n_checks++;
            if ({er1_clken, er2_clken, er1_update, er2_update} !== 4'b0) begin
               n_errors++;
               $display("FAIL ir_scan_strobes: got %b%b%b%b want 0000", er1_clken, er2_clken, er1_update, er2_update);
            end
            step(i == 7, v[i]);
         end
         step(1, 0);
         n_checks++;
         if (ir_out !== old) begin
            n_errors++;
            $display("FAIL ir_in_updir: got ir=%h want %h", ir_out, old);
         end
         step(0, 0);
         n_checks++;
         if (ir_out !== v) begin
            n_errors++;
            $display("FAIL ir_loaded: got ir=%h want %h", ir_out, v);
         end
      end
   endtask

   task automatic test_er_access();
      bit tseq [9] = '{1, 0, 0, 0, 0, 0, 1, 1, 0};
      logic [7:0] op;
      int ck, cap, upd, oth;
      logic want;
      for (int n = 0; n < 2; n++) begin
         op = (n == 0) ? 8'h32 : 8'h38;
         goto_rti(); scan_ir(op);
         ck = 0; cap = 0; upd = 0; oth = 0;
         for (int k = 0; k < 9; k++) begin
            er1_tdo = 1'($urandom); er2_tdo = 1'($urandom);
            step(tseq[k], 1'($urandom));
            ck  += int'(n == 0 ? er1_clken : er2_clken);
            upd += int'(n == 0 ? er1_update : er2_update);
            oth += int'(n == 0 ? (er2_clken | er2_update) : (er1_clken | er1_update));
            cap += int'(capture_dr);
            if (k >= 2 && k <= 5) begin
               want = (n == 0) ? er1_tdo : er2_tdo;
               n_checks++;
               if (tdo !== want) begin
                  n_errors++;
                  $display("FAIL er_tdo_pass op=%h k=%0d: got tdo=%b want %b", op, k, tdo, want);
               end
            end
         end
         n_checks++;
         if (ck != 5 || cap != 1 || upd != 1 || oth != 0) begin
            n_errors++;
            $display("FAIL er_strobe_counts op=%h: got clken=%0d cap=%0d upd=%0d other=%0d want 5 1 1 0",
                     op, ck, cap, upd, oth);
         end
      end
   endtask

   task automatic test_bypass();
      logic [7:0] op;
      logic [3:0] b;
      for (int n = 0; n < 4; n++) begin
         case (n)
            0: op = 8'hFF;
            1: op = 8'h55;
            default: begin
               op = 8'($urandom);
               while (op == 8'h32 || op == 8'h38 || (IDC && op == 8'h01)) op = 8'($urandom);
               if (n == 3 && !IDC) op = 8'h01;
            end
         endcase
         b = (n == 0) ? 4'b1101 : 4'($urandom);
         goto_rti(); scan_ir(op);
         step(1, 0); step(0, 0); step(0, 0);
         n_checks++;
         if (tdo !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_first op=%h: got tdo=%b want 0", op, tdo);
         end
         for (int i = 0; i < 4; i++) begin
            step(0, b[i]);
            n_checks++;
            if (tdo !== b[i]) begin
               n_errors++;
               $display("FAIL bypass_bit%0d op=%h: got tdo=%b want %b", i, op, tdo, b[i]);
            end
         end
         step(1, 0); step(1, 0); step(0, 0);
      end
   endtask

   task automatic test_idcode();
      logic [31:0] got, r, want;
      @(negedge clk); #1; rst = 1'b1; model_reset();
      @(negedge clk); #1; rst = 1'b0;
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 32; i++) begin
         got[i] = tdo; r[i] = 1'($urandom);
         step(i == 31, r[i]);
      end
      want = IDC ? IDV : {r[30:0], 1'b0};
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL idcode_stream: got %h want %h", got, want);
      end
      step(1, 0); step(0, 0);
   endtask

   task automatic test_random();
      logic [7:0] ops [4] = '{8'h32, 8'h38, 8'hFF, 8'h01};
      logic [18:0] exp_v, got_v;
      for (int n = 0; n < 600; n++) begin
         if (n % 100 == 0) begin goto_rti(); scan_ir(ops[$urandom_range(0, 3)]); end
         er1_tdo = 1'($urandom); er2_tdo = 1'($urandom);
         step($urandom_range(0, 99) < 40, 1'($urandom));
         exp_v = {m_st, m_ir, (m_st == S_SHIR || m_st == S_SHDR), (m_st == S_CAPDR),
                  (m_st == S_CAPDR || m_st == S_SHDR) && m_sel() == 1,
                  (m_st == S_CAPDR || m_st == S_SHDR) && m_sel() == 2,
                  (m_st == S_UPDDR) && m_sel() == 1, (m_st == S_UPDDR) && m_sel() == 2, m_tdo};
         got_v = {tap_state, ir_out, tdo_en, capture_dr, er1_clken, er2_clken, er1_update, er2_update, tdo};
         n_checks++;
         if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL random_step%0d: got %b want %b (st,ir,en,cap,ck1,ck2,up1,up2,tdo)", n, got_v, exp_v);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      init_table();
      model_reset();
      repeat (2) @(negedge clk);
      #1; rst = 1'b0;
      test_reset();
      test_tlr();
      test_ir_load();
      test_er_access();
      test_bypass();
      test_idcode();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
